// File: rtl/busca_instrucao_pkg.sv
// Shared constants, opcodes and state type for the instruction fetch stage.
package busca_instrucao_pkg;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 600;
  localparam int RESET_PC  = 0;

  localparam logic [5:0] OP_HLT   = 6'b010010;
  localparam logic [5:0] OP_JMP   = 6'b010101;
  localparam logic [5:0] OP_JAL   = 6'b010110;
  localparam logic [5:0] OP_JST   = 6'b010111;
  localparam logic [5:0] OP_SLEEP = 6'b011010;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // True when the word carries the hlt opcode in its top six bits.
  function automatic logic is_hlt(input logic [31:0] word);
    return word[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/busca_instrucao_fetch_skid.sv
// Two-entry ordered buffer: the instr output register plus one skid entry.
// Words leave strictly in the order they were pushed.
module fetch_skid #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       push_word,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              skid_valid
);

  logic [31:0]       skid_word;
  logic [ADDR_W-1:0] skid_pc;
  logic              consume;

  assign consume = instr_valid && pop;

  // Push/pop of the output register and skid entry; flush empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    if (!rst_n) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_word   <= '0;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        // Older skid word moves forward; a same-cycle return refills skid.
        instr       <= skid_word;
        instr_pc    <= skid_pc;
        instr_valid <= 1'b1;
        skid_valid  <= push;
        if (push) begin
          skid_word <= push_word;
          skid_pc   <= push_pc;
        end
      end else begin
        instr_valid <= push;
        if (push) begin
          instr    <= push_word;
          instr_pc <= push_pc;
        end
      end
    end else if (push) begin
      if (!instr_valid) begin
        instr       <= push_word;
        instr_pc    <= push_pc;
        instr_valid <= 1'b1;
      end else begin
        skid_word  <= push_word;
        skid_pc    <= push_pc;
        skid_valid <= 1'b1;
      end
    end
  end

  // The upstream credit check must never let a word arrive with both entries
  // held and nothing leaving.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && skid_valid && !consume));

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, reads the instruction memory with a
// one-cycle latency, and hands words to decode over valid/ready.
module busca_instrucao #(
  parameter int ADDR_W    = busca_instrucao_pkg::ADDR_W,
  parameter int MEM_DEPTH = busca_instrucao_pkg::MEM_DEPTH,
  parameter int RESET_PC  = busca_instrucao_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [31:0]       mem_saida,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  import busca_instrucao_pkg::*;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] req_pc;
  logic              req_valid;
  logic              skid_valid;
  logic              consume;
  logic [1:0]        occupancy;
  logic              can_issue;
  logic              issue;
  logic              ret_hlt;

  assign mem_endereco = pc;
  assign halted       = (state == HALTED);
  assign consume      = instr_valid && instr_ready;

  // Words held or in flight after this cycle's consume; at most two may be
  // outstanding so a returning word always has a slot.
  assign occupancy = 2'(instr_valid) + 2'(skid_valid) + 2'(req_valid);
  assign can_issue = (occupancy - 2'(consume)) < 2'd2;
  assign issue     = (state == RUN) && !redirect && can_issue;
  assign ret_hlt   = req_valid && is_hlt(mem_saida);

  assign pc_inc = (pc == ADDR_W'(MEM_DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
  assign redirect_target =
    (32'(redirect_pc) >= 32'(MEM_DEPTH)) ? '0 : redirect_pc;

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next state: redirect restarts fetch, a returning hlt stops it.
  always_comb begin
    // NOTE: the default assignment first keeps this purely combinational;
    // without it a path that skips the assignment would infer a latch.
    state_next = state;
    if (redirect)     state_next = RUN;
    else if (ret_hlt) state_next = HALTED;
  end

  // PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= ADDR_W'(RESET_PC);
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else if (redirect) begin
      pc        <= redirect_target;
      req_valid <= 1'b0;
    end else begin
      if (issue) begin
        pc     <= pc_inc;
        req_pc <= pc;
      end
      // A read issued alongside a returning hlt is past the halt: drop it.
      req_valid <= issue && !ret_hlt;
    end
  end

  fetch_skid #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect),
    .push        (req_valid),
    .push_word   (mem_saida),
    .push_pc     (req_pc),
    .pop         (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .skid_valid  (skid_valid)
  );

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: table-driven startup/stall vectors,
// hand-written halt/redirect/wrap/reset sequences, and a randomized run
// checked against an in-order delivery model.
module tb_busca_instrucao;
  import busca_instrucao_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_endereco;
  logic [31:0]   mem_saida;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halted;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit ready;
    int addr;
    bit valid;
    int pc;
  } vec_t;

  vec_t vecs [11];

  busca_instrucao dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_endereco (mem_endereco),
    .mem_saida    (mem_saida),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: word of the address presented in cycle t is on
  // mem_saida throughout cycle t+1.
  always @(posedge clk) mem_saida <= mem[mem_endereco];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {6'b001000, 6'd0, 10'(i), 10'(i)};
  endfunction

  function automatic int next_pc(input int p);
    return (p == DEPTH - 1) ? 0 : p + 1;
  endfunction

  task automatic fill_linear();
    for (int i = 0; i < 1024; i++) mem[i] = word_of(i);
    mem[1] = {OP_JMP, 26'd5};
  endtask

  // Leaves the bench at the negedge that starts cycle 0 after reset release.
  task automatic do_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input int exp_addr, input bit exp_valid, input int exp_pc);
    check({tag, ".addr"}, 32'(mem_endereco), 32'(exp_addr));
    check({tag, ".valid"}, 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      check({tag, ".pc"}, 32'(instr_pc), 32'(exp_pc));
      check({tag, ".instr"}, instr, mem[exp_pc]);
    end
  endtask

  int  exp_pc;
  bit  halt_done;
  int  gap;

  initial begin
    // Startup latency, then a 5-cycle stall and release.
    vecs[0]  = '{1'b1, 0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1, 1'b0, 0};
    vecs[2]  = '{1'b0, 2, 1'b1, 0};
    vecs[3]  = '{1'b0, 2, 1'b1, 0};
    vecs[4]  = '{1'b0, 2, 1'b1, 0};
    vecs[5]  = '{1'b0, 2, 1'b1, 0};
    vecs[6]  = '{1'b0, 2, 1'b1, 0};
    vecs[7]  = '{1'b1, 2, 1'b1, 0};
    vecs[8]  = '{1'b1, 3, 1'b1, 1};
    vecs[9]  = '{1'b1, 4, 1'b1, 2};
    vecs[10] = '{1'b1, 5, 1'b1, 3};

    fill_linear();
    do_reset();
    #1;
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.instr", instr, 32'd0);
    check("reset.instr_pc", 32'(instr_pc), 32'd0);
    for (int k = 0; k < 11; k++) begin
      instr_ready = vecs[k].ready;
      #1;
      check_out($sformatf("table[%0d]", k), vecs[k].addr, vecs[k].valid, vecs[k].pc);
      @(negedge clk);
    end

    // Halt at address 13 with decode always ready.
    fill_linear();
    mem[13] = {OP_HLT, 26'h0};
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      check($sformatf("run[%0d].addr", k), 32'(mem_endereco), 32'(k));
      if (k == 14) begin
        check("pre_hlt.halted", 32'(halted), 32'd0);
        check("pre_hlt.pc", 32'(instr_pc), 32'd12);
      end
      @(negedge clk);
    end
    #1;
    check_out("hlt", 15, 1'b1, 13);
    check("hlt.halted", 32'(halted), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check_out("halted_idle", 15, 1'b0, 0);
      check("halted_idle.halted", 32'(halted), 32'd1);
    end

    // Redirect to 2 while halted.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = AW'(2);
    #1;
    check("redir0.valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("redir1.halted", 32'(halted), 32'd0);
    check_out("redir1", 2, 1'b0, 0);
    @(negedge clk);
    #1;
    check_out("redir2", 3, 1'b0, 0);
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check_out("redir3", 4, 1'b1, 2);

    // Fill instr + skid, move skid forward, then redirect while a return lands.
    @(negedge clk);
    #1;
    check_out("skid_full", 4, 1'b1, 2);
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    check_out("skid_drain", 4, 1'b1, 2);
    @(negedge clk);
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = AW'(100);
    #1;
    check_out("flush0", 5, 1'b1, 3);
    @(negedge clk);
    redirect = 1'b0;
    instr_ready = 1'b1;
    #1;
    check_out("flush1", 100, 1'b0, 0);
    @(negedge clk);
    #1;
    check_out("flush2", 101, 1'b0, 0);
    @(negedge clk);
    #1;
    check_out("flush3", 102, 1'b1, 100);

    // PC wrap from 599 to 0.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = AW'(597);
    @(negedge clk);
    redirect = 1'b0;
    begin
      int wa [6];
      int wp [6];
      bit wv [6];
      wa = '{597, 598, 599, 0, 1, 2};
      wv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      wp = '{0, 0, 597, 598, 599, 0};
      for (int j = 0; j < 6; j++) begin
        #1;
        check_out($sformatf("wrap[%0d]", j), wa[j], wv[j], wp[j]);
        @(negedge clk);
      end
    end

    // Out-of-range redirect target loads 0.
    redirect = 1'b1;
    redirect_pc = AW'(700);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_out("clamp1", 0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_out("clamp3", 2, 1'b1, 0);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.valid", 32'(instr_valid), 32'd0);
    check("async_rst.addr", 32'(mem_endereco), 32'd0);
    check("async_rst.halted", 32'(halted), 32'd0);
    check("async_rst.instr", instr, 32'd0);
    check("async_rst.instr_pc", 32'(instr_pc), 32'd0);

    // Randomized run against an in-order delivery model.
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == OP_HLT) w[31:26] = 6'b000000;
      if ($urandom_range(0, 39) == 0) w[31:26] = OP_HLT;
      mem[i] = w;
    end
    do_reset();
    exp_pc    = 0;
    halt_done = 1'b0;
    gap       = 0;
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = AW'($urandom_range(0, 700));
      #1;
      if (instr_valid) begin
        gap = 0;
        if (halt_done) begin
          check("rand.after_hlt", 32'(instr_valid), 32'd0);
        end else begin
          check("rand.pc", 32'(instr_pc), 32'(exp_pc));
          check("rand.instr", instr, mem[exp_pc]);
          if (mem[exp_pc][31:26] == OP_HLT) check("rand.halted", 32'(halted), 32'd1);
        end
      end else if (!halt_done) begin
        gap++;
        check("rand.gap_ok", 32'(gap <= 3), 32'd1);
      end
      if (instr_valid && instr_ready && !halt_done) begin
        if (mem[exp_pc][31:26] == OP_HLT) halt_done = 1'b1;
        exp_pc = next_pc(exp_pc);
      end
      if (redirect) begin
        exp_pc    = (int'(redirect_pc) >= DEPTH) ? 0 : int'(redirect_pc);
        halt_done = 1'b0;
        gap       = 0;
      end
      @(negedge clk);
    end
    redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
